store_buffer: RTL and testbench

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/store_buffer.sv | 94 +++++++++
 tb/tb_store_buffer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// Post-MEM store buffer: queues stores in program order and drains them to the
// single-ported data memory whenever a load does not need the port.
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        st_valid,
  input  logic [2:0]  st_func3,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  output logic        st_ready,
  input  logic        ld_valid,
  input  logic [2:0]  ld_func3,
  input  logic [31:0] ld_addr,
  output logic        ld_stall,
  output logic        mem_wr,
  output logic [2:0]  mem_func3,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        sb_empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [2:0]       ent_func3 [DEPTH];
  logic [31:0]      ent_addr  [DEPTH];
  logic [31:0]      ent_data  [DEPTH];
  logic [DEPTH-1:0] ent_vld;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;

  logic enq;
  logic drain;
  logic hit;

  // Readiness looks only at the registered count, so a full buffer never
  // relies on a same-cycle drain to free a slot.
  assign st_ready = (count < FULL);
  assign sb_empty = (count == '0);
  assign enq      = st_valid && st_ready;

  // The data memory holds 64 words, so only addr[7:2] distinguishes locations.
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_vld[i] && (ent_addr[i][7:2] == ld_addr[7:2])) hit = 1'b1;
    end
  end

  assign ld_stall = ld_valid && hit;
  assign drain    = (count != '0) && (!ld_valid || ld_stall);

  assign mem_wr    = drain;
  assign mem_func3 = drain ? ent_func3[head] : ld_func3;
  assign mem_addr  = drain ? ent_addr[head]  : ld_addr;
  assign mem_wdata = drain ? ent_data[head]  : 32'h0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      ent_vld <= '0;
    end else begin
      if (enq) begin
        ent_vld[tail] <= 1'b1;
        tail          <= tail + 1'b1;
      end
      if (drain) begin
        ent_vld[head] <= 1'b0;
        head          <= head + 1'b1;
      end
      case ({enq, drain})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage carries no reset; validity is tracked by ent_vld.
  always_ff @(posedge clk) begin
    if (enq) begin
      ent_func3[tail] <= st_func3;
      ent_addr[tail]  <= st_addr;
      ent_data[tail]  <= st_data;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: drain timing, full handling, load
// hazards with address aliasing, pointer wrap and asynchronous reset.
module tb_store_buffer;

  logic        clk;
  logic        rst_n;
  logic        st_valid;
  logic [2:0]  st_func3;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_ready;
  logic        ld_valid;
  logic [2:0]  ld_func3;
  logic [31:0] ld_addr;
  logic        ld_stall;
  logic        mem_wr;
  logic [2:0]  mem_func3;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        sb_empty;

  int n_checks = 0;
  int n_fail   = 0;

  store_buffer #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .st_valid(st_valid), .st_func3(st_func3), .st_addr(st_addr), .st_data(st_data),
    .st_ready(st_ready),
    .ld_valid(ld_valid), .ld_func3(ld_func3), .ld_addr(ld_addr), .ld_stall(ld_stall),
    .mem_wr(mem_wr), .mem_func3(mem_func3), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .sb_empty(sb_empty)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_store(input logic v, input logic [2:0] f, input logic [31:0] a,
                           input logic [31:0] d);
    st_valid = v;
    st_func3 = f;
    st_addr  = a;
    st_data  = d;
  endtask

  logic [31:0] exp_q[$];
  int          k;
  int          writes;
  logic        exp_ready;

  initial begin
    rst_n    = 1'b0;
    set_store(1'b0, 3'd0, 32'h0, 32'h0);
    ld_valid = 1'b0;
    ld_func3 = 3'd2;
    ld_addr  = 32'h55;
    @(negedge clk);
    #1;
    check("rst_st_ready", st_ready, 1);
    check("rst_sb_empty", sb_empty, 1);
    check("rst_mem_wr", mem_wr, 0);
    check("rst_ld_stall", ld_stall, 0);
    check("rst_mem_addr", mem_addr, 32'h55);
    check("rst_mem_func3", mem_func3, 3'd2);
    @(negedge clk);
    rst_n = 1'b1;

    // Single SW, no load: write appears the next cycle, buffer empty after.
    set_store(1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
    #1;
    check("sw_ready", st_ready, 1);
    check("sw_no_same_cycle_wr", mem_wr, 0);
    cycle();
    set_store(1'b0, 3'd0, 32'h0, 32'h0);
    #1;
    check("sw_mem_wr", mem_wr, 1);
    check("sw_mem_addr", mem_addr, 32'h10);
    check("sw_mem_wdata", mem_wdata, 32'hDEADBEEF);
    check("sw_mem_func3", mem_func3, 3'd2);
    check("sw_not_empty", sb_empty, 0);
    cycle();
    #1;
    check("sw_empty_after", sb_empty, 1);
    check("sw_wr_done", mem_wr, 0);
    check("sw_wdata_zero", mem_wdata, 32'h0);

    // Five stores while an unrelated load owns the port; fifth is refused.
    ld_valid = 1'b1;
    ld_addr  = 32'h80;
    for (int i = 0; i < 5; i++) begin
      set_store(1'b1, 3'd2, (i == 4) ? 32'h30 : 32'(i * 4), 32'(i + 1));
      #1;
      check("fill_ready", st_ready, (i < 4) ? 1 : 0);
      check("fill_no_wr", mem_wr, 0);
      check("fill_ld_addr", mem_addr, 32'h80);
      check("fill_no_stall", ld_stall, 0);
      cycle();
    end
    set_store(1'b0, 3'd0, 32'h0, 32'h0);
    ld_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("drain_wr", mem_wr, 1);
      check("drain_addr", mem_addr, 32'(i * 4));
      check("drain_data", mem_wdata, 32'(i + 1));
      cycle();
    end
    #1;
    check("drain_empty", sb_empty, 1);
    check("drain_done", mem_wr, 0);

    // SB to 0x21 then LW 0x20: load stalls exactly one cycle.
    set_store(1'b1, 3'd0, 32'h21, 32'hAB);
    cycle();
    set_store(1'b0, 3'd0, 32'h0, 32'h0);
    ld_valid = 1'b1;
    ld_func3 = 3'd2;
    ld_addr  = 32'h20;
    #1;
    check("haz_stall", ld_stall, 1);
    check("haz_wr", mem_wr, 1);
    check("haz_addr", mem_addr, 32'h21);
    check("haz_func3", mem_func3, 3'd0);
    check("haz_data", mem_wdata, 32'hAB);
    cycle();
    #1;
    check("haz_release", ld_stall, 0);
    check("haz_release_wr", mem_wr, 0);
    check("haz_ld_addr", mem_addr, 32'h20);
    check("haz_ld_func3", mem_func3, 3'd2);

    // LW 0x120 aliases a pending store to 0x20 on bits [7:2].
    ld_valid = 1'b0;
    set_store(1'b1, 3'd2, 32'h20, 32'h77);
    cycle();
    set_store(1'b0, 3'd0, 32'h0, 32'h0);
    ld_valid = 1'b1;
    ld_addr  = 32'h120;
    #1;
    check("alias_stall", ld_stall, 1);
    check("alias_wr", mem_wr, 1);
    check("alias_addr", mem_addr, 32'h20);
    cycle();
    #1;
    check("alias_release", ld_stall, 0);
    check("alias_ld_addr", mem_addr, 32'h120);

    // Fill to DEPTH, then stream stores with no load; 12 stores wrap 3 times.
    ld_addr = 32'hFC;
    exp_q.delete();
    for (k = 0; k < 4; k++) begin
      set_store(1'b1, 3'd2, 32'(k * 4), 32'h1000 + 32'(k));
      #1;
      check("wrap_fill_ready", st_ready, 1);
      exp_q.push_back(32'(k * 4));
      cycle();
    end
    ld_valid = 1'b0;
    writes   = 0;
    for (int cyc = 0; cyc < 40 && (k < 12 || exp_q.size() != 0); cyc++) begin
      set_store(k < 12, 3'd2, 32'(k * 4), 32'h1000 + 32'(k));
      exp_ready = (exp_q.size() < 4);
      #1;
      check("wrap_ready", st_ready, exp_ready);
      if (exp_q.size() != 0) begin
        check("wrap_wr", mem_wr, 1);
        check("wrap_addr", mem_addr, exp_q[0]);
        check("wrap_data", mem_wdata, 32'h1000 + (exp_q[0] >> 2));
        void'(exp_q.pop_front());
        writes++;
      end else begin
        check("wrap_idle", mem_wr, 0);
      end
      if (st_valid && exp_ready) begin
        exp_q.push_back(32'(k * 4));
        k++;
      end
      cycle();
    end
    set_store(1'b0, 3'd0, 32'h0, 32'h0);
    #1;
    check("wrap_writes", 32'(writes), 32'd12);
    check("wrap_empty", sb_empty, 1);

    // Three pending stores discarded by an asynchronous reset mid-cycle.
    ld_valid = 1'b1;
    ld_addr  = 32'hFC;
    for (int i = 0; i < 3; i++) begin
      set_store(1'b1, 3'd2, 32'h40 + 32'(i * 4), 32'h5000 + 32'(i));
      cycle();
    end
    set_store(1'b0, 3'd0, 32'h0, 32'h0);
    #1;
    check("rst3_pending", sb_empty, 0);
    check("rst3_held", mem_wr, 0);
    ld_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("rst3_wr_now", mem_wr, 0);
    check("rst3_empty", sb_empty, 1);
    check("rst3_ready", st_ready, 1);
    cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("rst3_no_wr", mem_wr, 0);
      check("rst3_stay_empty", sb_empty, 1);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
